fp_adder_arbiter: RTL and testbench
===================================

Name: fp_adder_arbiter

Overview:
- Shares one pipelined FloatingPointAdder (IEEE-754 single, fixed latency, no handshake of its own) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready on the request side.
- Drives the adder's a/b operands and tracks each issued operation's requester ID through a tag pipeline matched to the adder latency.
- Returns each sum to its originator as a one-cycle response pulse, and caps the number of operations in flight.

Parameters:
NUM_REQ, 4, number of requesters (2..16); ID_W = $clog2(NUM_REQ), derived
DATA_W, 32, operand/result width (IEEE-754 single)
ADD_LATENCY, 3, adder result for operands applied at edge E is sampled at edge E+ADD_LATENCY; 1 = combinational adder; range 1..16
MAX_INFLIGHT, 3, maximum operations in the tag pipeline; 1..ADD_LATENCY

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester operation request
req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i] at a rising edge
req_a  in  NUM_REQ*DATA_W  operand a, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  operand b, same packing
add_a  out  DATA_W  registered operand a to adder
add_b  out  DATA_W  registered operand b to adder
add_result  in  DATA_W  adder sum
rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to the originating requester
rsp_data  out  DATA_W  sum, valid while any rsp_valid bit is set
inflight  out  $clog2(ADD_LATENCY+1)  operations currently in the tag pipeline

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: req_ready=0, add_a=0, add_b=0, rsp_valid=0, rsp_data=0, inflight=0.
  - Internal state: all tag-stage valids cleared, round-robin pointer ptr=0.
  - Operations in flight when reset asserts are discarded; no rsp_valid is produced for them after release.
- Arbitration (combinational each cycle):
  - Scan req_valid from index ptr upward, wrapping modulo NUM_REQ.
  - First set index w gets req_ready[w]=1; all other bits are 0.
  - No requester valid: req_ready=0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
  - A requester holds req_valid, req_a and req_b stable until its transfer.
- Throttle:
  - retire = tag stage ADD_LATENCY valid in the current cycle.
  - If inflight == MAX_INFLIGHT and retire=0, req_ready=0 for all requesters.
  - Issue and retire on the same edge are allowed; inflight is then unchanged.
- Issue, on a transfer edge E with winner w:
  - add_a <= req_a[w], add_b <= req_b[w].
  - Tag stage 1 <= {valid=1, id=w}.
  - ptr <= (w+1) mod NUM_REQ.
  - No transfer: add_a/add_b hold their previous values, stage 1 valid <= 0, ptr unchanged.
- Tag pipeline:
  - ADD_LATENCY stages; each edge shifts stage k into stage k+1.
  - inflight = number of valid stages; registered, +1 on issue, -1 on retire, both = no change.
- Response, at each edge:
  - rsp_valid <= onehot(stage ADD_LATENCY id) if that stage is valid, else 0.
  - rsp_data <= add_result when that stage is valid, else hold.
  - Latency: transfer at edge E gives rsp_valid high for exactly the cycle beginning at edge E+ADD_LATENCY.
  - Responses arrive in issue order. There is no response backpressure; requesters must accept rsp_valid unconditionally.
- Throughput: one issue per cycle when MAX_INFLIGHT=ADD_LATENCY. A single continuously-valid requester transfers every cycle when it is the only one valid.
- Fairness: with all requesters continuously valid and no throttling, grants cycle 0,1,...,NUM_REQ-1,0,...
- The arbiter does no arithmetic on the data. Special values (NaN, Inf, zero) pass through untouched.

Test Plan:
- Basic single request: bench adder is a behavioural model with ADD_LATENCY=3. Requester 1 issues a=3F800000 (1.0), b=40000000 (2.0), handshake at edge E. Required: add_a=3F800000 after E; rsp_valid=0010 and rsp_data=40400000 (3.0) for exactly the cycle at E+3; inflight goes 1,1,1,0.
- Full contention: all 4 req_valid high from reset release, each with distinct operands. Required: grants 0,1,2,3,0 on consecutive edges; each rsp_valid pulse has the matching id and sum, 3 cycles after its grant.
- Pointer wrap: grant to 2, then req_valid=1010. Required: next grant goes to 3, then to 1; an idle cycle with req_valid=0000 leaves ptr unchanged.
- Throttle: MAX_INFLIGHT=1, requester 0 continuously valid. Required: transfers only every 3 cycles (issue edge equals retire edge of the prior op); inflight never exceeds 1; req_ready=0 while inflight=1 and no retire.
- Reset mid-operation: 3 ops in flight, pull rst low asynchronously between edges. Required: rsp_valid, req_ready and inflight go 0 immediately; after release no stale rsp_valid appears and the first grant goes to the lowest valid index (ptr=0).
- Back-to-back single requester: requester 3 valid for 5 cycles with operands 1.0+1.0 through 5.0+1.0. Required: 5 consecutive rsp_valid=1000 pulses with rsp_data 40000000, 40400000, 40800000, 40A00000, 40C00000.

Source files
------------

// File: rtl/fp_adder_arbiter_if.sv
// Request/response bus between NUM_REQ requesters and the shared-adder arbiter.
// Requesters use the master modport, the arbiter uses the slave modport.
interface fp_adder_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_a;
   logic [NUM_REQ*DATA_W-1:0] req_b;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/fp_adder_arbiter.sv
// Round-robin front end sharing one fixed-latency pipelined FP adder among
// NUM_REQ requesters; a tag pipeline routes each sum back to its originator.
module fp_adder_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 32,
   parameter int ADD_LATENCY  = 3,
   parameter int MAX_INFLIGHT = 3,
   localparam int ID_W        = $clog2(NUM_REQ),
   localparam int CNT_W       = $clog2(ADD_LATENCY + 1)
) (
   input  logic              clk,
   input  logic              rst,
   fp_adder_arbiter_if.slave bus,
   output logic [DATA_W-1:0] add_a,
   output logic [DATA_W-1:0] add_b,
   input  logic [DATA_W-1:0] add_result,
   output logic [CNT_W-1:0]  inflight
);

   logic [ID_W-1:0]        ptr;
   logic [ID_W-1:0]        scan_id;
   logic [ID_W-1:0]        win_id;
   logic                   found;
   logic                   retire;
   logic                   throttle;
   logic                   transfer;
   logic [NUM_REQ-1:0]     grant;
   logic [ADD_LATENCY-1:0] tag_valid;
   logic [ID_W-1:0]        tag_id [ADD_LATENCY];
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [DATA_W-1:0]      rsp_data;

   // The last tag stage retiring frees a slot on the same edge a new op issues.
   assign retire   = tag_valid[ADD_LATENCY-1];
   assign throttle = (inflight == CNT_W'(MAX_INFLIGHT)) && !retire;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      grant   = '0;
      found   = 1'b0;
      win_id  = '0;
      scan_id = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_id = ID_W'((int'(ptr) + i) % NUM_REQ);
         if (!found && bus.req_valid[scan_id]) begin
            found  = 1'b1;
            win_id = scan_id;
         end
      end
      if (found && !throttle && rst) grant[win_id] = 1'b1;
   end

   assign transfer      = |grant;
   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rsp_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr       <= '0;
         add_a     <= '0;
         add_b     <= '0;
         tag_valid <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         inflight  <= '0;
      end else begin
         tag_valid <= (tag_valid << 1) | ADD_LATENCY'(transfer);

         if (transfer) begin
            add_a <= bus.req_a[win_id*DATA_W +: DATA_W];
            add_b <= bus.req_b[win_id*DATA_W +: DATA_W];
            ptr   <= ID_W'((int'(win_id) + 1) % NUM_REQ);
         end

         if (retire) begin
            rsp_valid <= NUM_REQ'(1) << tag_id[ADD_LATENCY-1];
            rsp_data  <= add_result;
         end else begin
            rsp_valid <= '0;
         end

         if (transfer && !retire) begin
            inflight <= inflight + 1'b1;
         end else if (!transfer && retire) begin
            inflight <= inflight - 1'b1;
         end
      end
   end

   // NOTE: ids are payload qualified by tag_valid, so this array needs no reset.
   always_ff @(posedge clk) begin
      tag_id[0] <= win_id;
      for (int k = 1; k < ADD_LATENCY; k++) begin
         tag_id[k] <= tag_id[k-1];
      end
   end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Bench for fp_adder_arbiter: two instances (MAX_INFLIGHT 3 and 1) driving
// behavioural 3-cycle FP adders, with a response scoreboard per instance.
module tb_fp_adder_arbiter;

   localparam int N = 4;
   localparam int W = 32;
   localparam int L = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fp_adder_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus0 ();
   fp_adder_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus1 ();

   logic [W-1:0] add_a0, add_b0, add_res0;
   logic [W-1:0] add_a1, add_b1, add_res1;
   logic [1:0]   infl0, infl1;

   fp_adder_arbiter #(.NUM_REQ(N), .DATA_W(W), .ADD_LATENCY(L), .MAX_INFLIGHT(3)) dut (
      .clk(clk), .rst(rst), .bus(bus0),
      .add_a(add_a0), .add_b(add_b0), .add_result(add_res0), .inflight(infl0)
   );

   fp_adder_arbiter #(.NUM_REQ(N), .DATA_W(W), .ADD_LATENCY(L), .MAX_INFLIGHT(1)) dut_t (
      .clk(clk), .rst(rst), .bus(bus1),
      .add_a(add_a1), .add_b(add_b1), .add_result(add_res1), .inflight(infl1)
   );

   // Single <-> double conversion for normal numbers and zero.
   function automatic real sp2r(logic [31:0] x);
      logic [63:0] d;
      if (x[30:0] == 31'd0) d = {x[31], 63'd0};
      else d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   // Behavioural adders: operands applied at edge E are sampled at edge E+3.
   logic [W-1:0] p0_s1, p0_s2, p1_s1, p1_s2;
   always @(posedge clk) begin
      p0_s1 <= r2sp(sp2r(add_a0) + sp2r(add_b0));
      p0_s2 <= p0_s1;
      p1_s1 <= r2sp(sp2r(add_a1) + sp2r(add_b1));
      p1_s2 <= p1_s1;
   end
   assign add_res0 = p0_s2;
   assign add_res1 = p1_s2;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      int           due;
      int           id;
      logic [W-1:0] data;
   } exp_t;

   typedef struct {
      logic [N-1:0] valid;
      logic [N-1:0] ready;
   } vec_t;

   exp_t q0[$];
   exp_t q1[$];
   int   cnt[N];
   int   t_cnt = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_rsp();
      exp_t e;
      if (q0.size() > 0 && q0[0].due == cyc) begin
         e = q0.pop_front();
         check("rsp_valid", 64'(bus0.rsp_valid), 64'(4'b0001 << e.id));
         check("rsp_data", 64'(bus0.rsp_data), 64'(e.data));
      end else if (bus0.rsp_valid !== '0) begin
         check("rsp_unexpected", 64'(bus0.rsp_valid), 64'd0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
         e = q1.pop_front();
         check("t_rsp_valid", 64'(bus1.rsp_valid), 64'(4'b0001 << e.id));
         check("t_rsp_data", 64'(bus1.rsp_data), 64'(e.data));
      end else if (bus1.rsp_valid !== '0) begin
         check("t_rsp_unexpected", 64'(bus1.rsp_valid), 64'd0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      check_rsp();
   endtask

   function automatic logic [31:0] op_a(int i);
      return r2sp(real'(16 * i + cnt[i] + 1));
   endfunction

   function automatic logic [31:0] op_b(int i);
      return r2sp(real'(i + 2));
   endfunction

   function automatic logic [31:0] exp_sum(int i);
      return r2sp(real'(16 * i + cnt[i] + 1 + i + 2));
   endfunction

   task automatic drive_ops();
      for (int i = 0; i < N; i++) begin
         bus0.req_a[i*W +: W] = op_a(i);
         bus0.req_b[i*W +: W] = op_b(i);
      end
   endtask

   // One cycle on dut: drive, check the grant, record the expected response.
   task automatic issue_row(logic [N-1:0] valid, logic [N-1:0] exp_ready, string name);
      logic [W-1:0] ea;
      logic         xfer;
      xfer = 1'b0;
      ea   = '0;
      bus0.req_valid = valid;
      drive_ops();
      #1;
      check(name, 64'(bus0.req_ready), 64'(exp_ready));
      for (int i = 0; i < N; i++) begin
         if (exp_ready[i] && valid[i]) begin
            q0.push_back('{due: cyc + L + 1, id: i, data: exp_sum(i)});
            ea   = op_a(i);
            xfer = 1'b1;
            cnt[i]++;
         end
      end
      step();
      if (xfer) check("add_a", 64'(add_a0), 64'(ea));
   endtask

   vec_t tbl[16];
   logic [31:0] b2b_a[5];
   logic [31:0] b2b_s[5];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      // Contention, drain, pointer wrap and idle-cycle rows, starting at ptr=0.
      tbl = '{
         '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100},
         '{4'b1111, 4'b1000}, '{4'b1111, 4'b0001}, '{4'b1110, 4'b0010},
         '{4'b1100, 4'b0100}, '{4'b1000, 4'b1000}, '{4'b0100, 4'b0100},
         '{4'b1010, 4'b1000}, '{4'b0010, 4'b0010}, '{4'b0000, 4'b0000},
         '{4'b0110, 4'b0100}, '{4'b0010, 4'b0010}, '{4'b1001, 4'b1000},
         '{4'b0001, 4'b0001}
      };
      b2b_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
      b2b_s = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};

      for (int i = 0; i < N; i++) cnt[i] = 0;
      bus0.req_valid = 4'b1111;
      bus0.req_a = '0;
      bus0.req_b = '0;
      bus1.req_valid = '0;
      bus1.req_a = '0;
      bus1.req_b = '0;
      drive_ops();

      // Reset state, with requests already pending.
      repeat (2) @(negedge clk);
      check("rst_req_ready", 64'(bus0.req_ready), 64'd0);
      check("rst_add_a", 64'(add_a0), 64'd0);
      check("rst_add_b", 64'(add_b0), 64'd0);
      check("rst_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(bus0.rsp_data), 64'd0);
      check("rst_inflight", 64'(infl0), 64'd0);
      check("rst_t_req_ready", 64'(bus1.req_ready), 64'd0);
      rst = 1'b1;

      for (int r = 0; r < 16; r++) issue_row(tbl[r].valid, tbl[r].ready, $sformatf("grant_row%0d", r));
      bus0.req_valid = '0;
      repeat (4) step();

      // Basic single request from requester 1 (ptr is 1 here).
      bus0.req_valid = 4'b0010;
      bus0.req_a[1*W +: W] = 32'h3F800000;
      bus0.req_b[1*W +: W] = 32'h40000000;
      #1;
      check("basic_ready", 64'(bus0.req_ready), 64'b0010);
      q0.push_back('{due: cyc + L + 1, id: 1, data: 32'h40400000});
      step();
      bus0.req_valid = '0;
      check("basic_add_a", 64'(add_a0), 64'h3F800000);
      check("basic_add_b", 64'(add_b0), 64'h40000000);
      check("basic_inflight0", 64'(infl0), 64'd1);
      step();
      check("basic_inflight1", 64'(infl0), 64'd1);
      step();
      check("basic_inflight2", 64'(infl0), 64'd1);
      step();
      check("basic_inflight3", 64'(infl0), 64'd0);

      // Back-to-back requester 3: k.0 + 1.0 for k = 1..5.
      for (int k = 0; k < 5; k++) begin
         bus0.req_valid = 4'b1000;
         bus0.req_a[3*W +: W] = b2b_a[k];
         bus0.req_b[3*W +: W] = 32'h3F800000;
         #1;
         check("b2b_ready", 64'(bus0.req_ready), 64'b1000);
         q0.push_back('{due: cyc + L + 1, id: 3, data: b2b_s[k]});
         step();
      end
      bus0.req_valid = '0;
      repeat (4) step();

      // Reset with three ops in flight and ptr=1; no stale responses afterwards.
      issue_row(4'b0111, 4'b0001, "mid_grant0");
      issue_row(4'b0111, 4'b0010, "mid_grant1");
      issue_row(4'b0111, 4'b0100, "mid_grant2");
      issue_row(4'b0111, 4'b0001, "mid_grant3");
      check("mid_inflight", 64'(infl0), 64'd3);
      #2;
      rst = 1'b0;
      #1;
      check("async_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
      check("async_req_ready", 64'(bus0.req_ready), 64'd0);
      check("async_inflight", 64'(infl0), 64'd0);
      q0.delete();
      q1.delete();
      step();
      step();
      rst = 1'b1;
      issue_row(4'b0011, 4'b0001, "post_rst_grant0");
      issue_row(4'b0010, 4'b0010, "post_rst_grant1");
      bus0.req_valid = '0;
      repeat (5) step();

      // Throttle: MAX_INFLIGHT=1, requester 0 continuously valid.
      for (int c = 0; c < 10; c++) begin
         bus1.req_valid = 4'b0001;
         bus1.req_a[0 +: W] = r2sp(real'(t_cnt + 1));
         bus1.req_b[0 +: W] = 32'h40000000;
         #1;
         check("throttle_ready", 64'(bus1.req_ready), (c % 3 == 0) ? 64'b0001 : 64'd0);
         check("throttle_inflight", 64'(infl1), (c == 0) ? 64'd0 : 64'd1);
         if (c % 3 == 0) begin
            q1.push_back('{due: cyc + L + 1, id: 0, data: r2sp(real'(t_cnt + 3))});
            t_cnt++;
         end
         step();
      end
      bus1.req_valid = '0;
      repeat (4) step();

      check("q0_drained", 64'(q0.size()), 64'd0);
      check("q1_drained", 64'(q1.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
